// File: rtl/pipe_arith_pkg.sv
// Shared types and defaults for the pipelined slice arithmetic blocks.
// Holds operand/slice widths and the per-stage payload carried down the pipe.
package pipe_arith_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int SLICE_DEF = 2;
    localparam int NSTG      = WIDTH_DEF / SLICE_DEF;

    // Payload of one pipeline register.
    // low_diff fills from the top: each stage shifts in its resolved slice.
    // high_a/high_b shift down so the slice to resolve always sits at bit 0.
    typedef struct packed {
        logic                 valid;
        logic                 borrow;
        logic [WIDTH_DEF-1:0] low_diff;
        logic [WIDTH_DEF-1:0] high_a;
        logic [WIDTH_DEF-1:0] high_b;
    } stage_t;

endpackage

// File: rtl/pipeline_sub_slice.sv
// Combinational SLICE-bit subtractor with borrow in and borrow out.
// Ports: a, b (operand slices), bin (borrow in), diff (slice result), bout.
module sub_slice
    import pipe_arith_pkg::*;
#(
    parameter int SLICE = SLICE_DEF
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] diff,
    output logic             bout
);

    logic [SLICE:0] res;

    // Extended by one bit so the MSB is the borrow.
    always_comb begin
        res = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
    end

    assign diff = res[SLICE-1:0];
    assign bout = res[SLICE];

endmodule

// File: rtl/pipeline_sub.sv
// Pipelined subtractor: {bout, diff} = ina - inb - bin, one slice per stage,
// behind an input register, with a valid/ready handshake and back-pressure.
// Ports: clk, rst_n (async, active low), in_valid/in_ready/ina/inb/bin on the
// input side; out_valid/out_ready/diff/bout on the output side.
module pipeline_sub
    import pipe_arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int NST = WIDTH / SLICE;

    // st_q[0] is the input register; st_q[k] holds the result of k slices.
    // The final slice result lands directly in the output registers.
    stage_t st_q [NST];
    stage_t st_d [NST];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic adv;

    logic [NST-1:0][SLICE-1:0] sl_a;
    logic [NST-1:0][SLICE-1:0] sl_b;
    logic [NST-1:0][SLICE-1:0] sl_d;
    logic [NST-1:0]            sl_bi;
    logic [NST-1:0]            sl_bo;

    // Slice k resolves the operand bits currently held in st_q[k].
    for (genvar k = 0; k < NST; k++) begin : g_slice
        assign sl_a[k]  = st_q[k].high_a[SLICE-1:0];
        assign sl_b[k]  = st_q[k].high_b[SLICE-1:0];
        assign sl_bi[k] = st_q[k].borrow;

        sub_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a   (sl_a[k]),
            .b   (sl_b[k]),
            .bin (sl_bi[k]),
            .diff(sl_d[k]),
            .bout(sl_bo[k])
        );
    end

    function automatic stage_t shift_stage(
        input stage_t           p,
        input logic [SLICE-1:0] d,
        input logic             bo
    );
        stage_t r;
        r          = p;
        r.borrow   = bo;
        r.low_diff = {d, p.low_diff[WIDTH-1:SLICE]};
        r.high_a   = p.high_a >> SLICE;
        r.high_b   = p.high_b >> SLICE;
        return r;
    endfunction

    // Whole pipe moves in lockstep; it stalls only when the output is held.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        st_d        = st_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        if (adv) begin
            st_d[0]        = '0;
            st_d[0].valid  = in_valid;
            st_d[0].borrow = bin;
            st_d[0].high_a = ina;
            st_d[0].high_b = inb;
            for (int i = 1; i < NST; i++) begin
                st_d[i] = shift_stage(st_q[i-1], sl_d[i-1], sl_bo[i-1]);
            end
            out_valid_d = st_q[NST-1].valid;
            bout_d      = sl_bo[NST-1];
            diff_d      = {sl_d[NST-1], st_q[NST-1].low_diff[WIDTH-1:SLICE]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NST; i++) begin
                st_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_pipeline_sub.sv
// Self-checking bench for pipeline_sub: directed vector table, latency,
// back-pressure, mid-stream reset and a random soak against a scoreboard.
module tb_pipeline_sub;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ina;
    logic [7:0] inb;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_ret = 0;

    logic [7:0] exp_d;
    logic       exp_b;
    logic [8:0] sb[$];
    bit         held = 0;
    logic [8:0] held_v;
    bit         soak_on = 0;

    pipeline_sub dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ina      (ina),
        .inb      (inb),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic bi);
        return {1'b0, a} - {1'b0, b} - {8'd0, bi};
    endfunction

    // Output-side monitor: handshake rule, hold stability, scoreboard order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (held) begin
                total++;
                if (!out_valid || {bout, diff} !== held_v) begin
                    bad++;
                    $display("FAIL hold: got v=%0b %h required v=1 %h",
                             out_valid, {bout, diff}, held_v);
                end
            end
            held   = out_valid && !out_ready;
            held_v = {bout, diff};
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("FAIL in_ready: got %0b required %0b",
                         in_ready, (!out_valid || out_ready));
            end
            if (out_valid && out_ready) begin
                n_ret++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL result: got %h with none expected", {bout, diff});
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    if ({bout, diff} !== e) begin
                        bad++;
                        $display("FAIL result: got bout,diff=%h required %h",
                                 {bout, diff}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                sb.push_back({exp_b, exp_d});
            end
        end else begin
            held = 0;
            sb.delete();
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Presents one op and returns just after the edge that accepted it.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb);
        int  n;
        bit  acc;
        n   = 0;
        acc = 0;
        ina = a; inb = b; bin = bi;
        exp_d = ed; exp_b = eb;
        in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
            if (!acc && n > 200) begin
                total++;
                bad++;
                $display("FAIL send timeout: got in_ready=0 required 1");
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vt [10];

    logic [7:0] bpa [6];
    logic [7:0] bpb [6];
    logic       bpc [6];

    initial begin
        vt[0] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vt[1] = '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1};
        vt[2] = '{8'hC3, 8'h41, 1'b0, 8'h82, 1'b0};
        vt[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vt[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vt[5] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
        vt[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vt[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
        vt[8] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
        vt[9] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};

        bpa = '{8'h11, 8'h33, 8'hFE, 8'h00, 8'h9C, 8'h40};
        bpb = '{8'h22, 8'h11, 8'h01, 8'h80, 8'h9C, 8'h3F};
        bpc = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ina = '0; inb = '0; bin = 1'b0;
        exp_d = '0; exp_b = 1'b0;
        step();
        step();
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset diff", 32'(diff), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle out_valid", 32'(out_valid), 0);
            chk("idle in_ready", 32'(in_ready), 1);
            chk("idle diff", 32'(diff), 0);
            chk("idle bout", 32'(bout), 0);
        end

        // Single op: output on the fifth edge counting the accepting one.
        send(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("single early out_valid", 32'(out_valid), 0);
            step();
        end
        chk("single early out_valid", 32'(out_valid), 0);
        step();
        chk("single out_valid", 32'(out_valid), 1);
        chk("single diff", 32'(diff), 32'hFF);
        chk("single bout", 32'(bout), 1);
        step();
        chk("single one-shot", 32'(out_valid), 0);

        // Back-to-back: four results on consecutive cycles, in order.
        for (int i = 0; i < 4; i++) begin
            send(vt[i].a, vt[i].b, vt[i].bi, vt[i].d, vt[i].bo);
        end
        idle();
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                step();
                n++;
            end
            chk("b2b arrival", 32'(out_valid), 1);
        end
        for (int i = 0; i < 4; i++) begin
            chk("b2b valid", 32'(out_valid), 1);
            chk("b2b diff", 32'(diff), 32'(vt[i].d));
            chk("b2b bout", 32'(bout), 32'(vt[i].bo));
            step();
        end
        chk("b2b end", 32'(out_valid), 0);

        // Remaining table entries, one at a time with latency checked.
        for (int i = 4; i < 10; i++) begin
            send(vt[i].a, vt[i].b, vt[i].bi, vt[i].d, vt[i].bo);
            idle();
            step();
            step();
            step();
            chk("vec early", 32'(out_valid), 0);
            step();
            chk("vec valid", 32'(out_valid), 1);
            chk("vec diff", 32'(diff), 32'(vt[i].d));
            chk("vec bout", 32'(bout), 32'(vt[i].bo));
        end
        step();

        // Back-pressure: output held for 8 cycles with the pipe full.
        begin
            int a0;
            int r0;
            a0 = n_acc;
            r0 = n_ret;
            fork
                begin
                    for (int i = 0; i < 6; i++) begin
                        logic [8:0] m;
                        m = model(bpa[i], bpb[i], bpc[i]);
                        send(bpa[i], bpb[i], bpc[i], m[7:0], m[8]);
                    end
                    idle();
                end
                begin
                    step();
                    step();
                    step();
                    out_ready = 1'b0;
                    for (int i = 0; i < 8; i++) step();
                    chk("bp in_ready held", 32'(in_ready), 0);
                    chk("bp out_valid held", 32'(out_valid), 1);
                    chk("bp head diff", 32'(diff), 32'hEF);
                    out_ready = 1'b1;
                end
            join
            for (int i = 0; i < 12; i++) step();
            chk("bp accepted", 32'(n_acc - a0), 6);
            chk("bp retired", 32'(n_ret - r0), 6);
            chk("bp drained", 32'(sb.size()), 0);
        end

        // Mid-stream reset with three ops in flight.
        for (int i = 0; i < 3; i++) begin
            send(8'h50 + 8'(i), 8'h01, 1'b0, 8'h4F + 8'(i), 1'b0);
        end
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst async out_valid", 32'(out_valid), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post-rst quiet", 32'(out_valid), 0);
        end
        send(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
        idle();
        step();
        step();
        step();
        chk("post-rst early", 32'(out_valid), 0);
        step();
        chk("post-rst valid", 32'(out_valid), 1);
        chk("post-rst diff", 32'(diff), 32'hF0);
        chk("post-rst bout", 32'(bout), 1);
        step();

        // Random soak with random gaps and random back-pressure.
        soak_on = 1;
        fork
            begin
                while (soak_on) begin
                    step();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [7:0] a;
                    logic [7:0] b;
                    logic       c;
                    logic [8:0] m;
                    a = 8'($urandom);
                    b = 8'($urandom);
                    c = 1'($urandom);
                    m = model(a, b, c);
                    send(a, b, c, m[7:0], m[8]);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        step();
                    end
                end
                idle();
                soak_on = 0;
            end
        join
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 100) begin
                step();
                n++;
            end
        end
        chk("soak drained", 32'(sb.size()), 0);
        chk("soak count", 32'(n_ret - n_acc), 32'(-3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
